// File: rtl/ps2_kbd_pkg.sv
// Shared scan-code constants and FSM state type for the PS/2 keyboard sequencer.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } kbd_state_e;

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational Set-2 scan code to ASCII map (lower-case letters, digits, space).
// Only instantiated when PS2_KBD_ASCII_EN is defined.
module ps2_ascii_lut (
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: ascii = 8'h61;
                8'h32: ascii = 8'h62;
                8'h21: ascii = 8'h63;
                8'h23: ascii = 8'h64;
                8'h24: ascii = 8'h65;
                8'h2B: ascii = 8'h66;
                8'h34: ascii = 8'h67;
                8'h33: ascii = 8'h68;
                8'h43: ascii = 8'h69;
                8'h3B: ascii = 8'h6A;
                8'h42: ascii = 8'h6B;
                8'h4B: ascii = 8'h6C;
                8'h3A: ascii = 8'h6D;
                8'h31: ascii = 8'h6E;
                8'h44: ascii = 8'h6F;
                8'h4D: ascii = 8'h70;
                8'h15: ascii = 8'h71;
                8'h2D: ascii = 8'h72;
                8'h1B: ascii = 8'h73;
                8'h2C: ascii = 8'h74;
                8'h3C: ascii = 8'h75;
                8'h2A: ascii = 8'h76;
                8'h1D: ascii = 8'h77;
                8'h22: ascii = 8'h78;
                8'h35: ascii = 8'h79;
                8'h1A: ascii = 8'h7A;
                8'h45: ascii = 8'h30;
                8'h16: ascii = 8'h31;
                8'h1E: ascii = 8'h32;
                8'h26: ascii = 8'h33;
                8'h25: ascii = 8'h34;
                8'h2E: ascii = 8'h35;
                8'h36: ascii = 8'h36;
                8'h3D: ascii = 8'h37;
                8'h3E: ascii = 8'h38;
                8'h46: ascii = 8'h39;
                8'h29: ascii = 8'h20;
                default: ascii = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 receiver FIFO consumer: strips E0/F0 prefixes, emits key events, tracks the held key.
// Define PS2_KBD_ASCII_EN to add the key_ascii output and its lookup table.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_ready,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_overflow,
    output logic             ps2_nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic             key_held,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic [CNT_W-1:0] press_count,
    output logic             overflow_seen,
`ifdef PS2_KBD_ASCII_EN
    output logic [7:0]       key_ascii,
`endif
    output kbd_state_e       state_dbg
);

    // Handshake: the head byte is taken when ps2_ready is sampled high in IDLE;
    // ps2_nextdata_n is then low for exactly one cycle (POP) to pop it, and GAP
    // lets ready settle before it is looked at again. key_valid has no backpressure.
    kbd_state_e state;
    logic       ext_q;
    logic       brk_q;
    logic [7:0] byte_q;
    logic       held_match;

    assign held_match = key_held && (held_code == byte_q) && (held_ext == ext_q);
    assign state_dbg  = state;

`ifdef PS2_KBD_ASCII_EN
    logic [7:0] ascii_c;

    ps2_ascii_lut u_ascii_lut (
        .code  (byte_q),
        .ext   (ext_q),
        .ascii (ascii_c)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ext_q          <= 1'b0;
            brk_q          <= 1'b0;
            byte_q         <= 8'h00;
            ps2_nextdata_n <= 1'b1;
            key_valid      <= 1'b0;
            key_code       <= 8'h00;
            key_ext        <= 1'b0;
            key_release    <= 1'b0;
            key_held       <= 1'b0;
            held_code      <= 8'h00;
            held_ext       <= 1'b0;
            press_count    <= '0;
            overflow_seen  <= 1'b0;
`ifdef PS2_KBD_ASCII_EN
            key_ascii      <= 8'h00;
`endif
        end else begin
            key_valid     <= 1'b0;
            overflow_seen <= overflow_seen | ps2_overflow;
            case (state)
                IDLE: begin
                    if (ps2_ready) begin
                        byte_q         <= ps2_data;
                        ps2_nextdata_n <= 1'b0;
                        state          <= POP;
                    end
                end
                POP: begin
                    ps2_nextdata_n <= 1'b1;
                    state          <= GAP;
                    if (byte_q == SC_EXT) begin
                        ext_q <= 1'b1;
                    end else if (byte_q == SC_BRK) begin
                        brk_q <= 1'b1;
                    end else begin
                        key_valid   <= 1'b1;
                        key_code    <= byte_q;
                        key_ext     <= ext_q;
                        key_release <= brk_q;
`ifdef PS2_KBD_ASCII_EN
                        key_ascii   <= ascii_c;
`endif
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                        // A make of the already-held key is a typematic repeat.
                        if (!brk_q) begin
                            if (!held_match) begin
                                press_count <= press_count + CNT_W'(1);
                                key_held    <= 1'b1;
                                held_code   <= byte_q;
                                held_ext    <= ext_q;
                            end
                        end else if (held_match) begin
                            key_held <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl with a queue-based model of the PS/2 receiver FIFO.
module tb_ps2_kbd_ctrl;
    import ps2_kbd_pkg::*;

    logic       clk;
    logic       rst;
    logic       ps2_ready;
    logic [7:0] ps2_data;
    logic       ps2_overflow;
    logic       ps2_nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_held;
    logic [7:0] held_code;
    logic       held_ext;
    logic [7:0] press_count;
    logic       overflow_seen;
    kbd_state_e state_dbg;
`ifdef PS2_KBD_ASCII_EN
    logic [7:0] key_ascii;
    logic [7:0] asc_q[$];
`endif

    logic [7:0] fifo[$];
    logic [9:0] ev_q[$];
    logic [9:0] exp_q[$];
    int         pop_cnt;
    int         n_tests;
    int         n_fail;

    ps2_kbd_ctrl #(.CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2_ready      (ps2_ready),
        .ps2_data       (ps2_data),
        .ps2_overflow   (ps2_overflow),
        .ps2_nextdata_n (ps2_nextdata_n),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_ext        (key_ext),
        .key_release    (key_release),
        .key_held       (key_held),
        .held_code      (held_code),
        .held_ext       (held_ext),
        .press_count    (press_count),
        .overflow_seen  (overflow_seen),
`ifdef PS2_KBD_ASCII_EN
        .key_ascii      (key_ascii),
`endif
        .state_dbg      (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ev(input logic [7:0] code, input logic ext, input logic rel);
        return {code, ext, rel};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        ps2_ready = (fifo.size() != 0);
        ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    // Receiver model: pops on the pop strobe; the monitor records every event.
    always @(negedge clk) begin
        if (!ps2_nextdata_n) begin
            pop_cnt++;
            if (fifo.size() > 0) void'(fifo.pop_front());
            refresh();
        end
        if (key_valid) begin
            ev_q.push_back({key_code, key_ext, key_release});
`ifdef PS2_KBD_ASCII_EN
            asc_q.push_back(key_ascii);
`endif
        end
    end

    // Driver tasks (all called at #1 after a rising edge)
    task automatic send(input logic [7:0] b);
        fifo.push_back(b);
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_nextdata_n", ps2_nextdata_n, 1);
        check("rst_key_outs", {key_valid, key_code, key_ext, key_release}, 0);
        check("rst_held_outs", {key_held, held_code, held_ext}, 0);
        check("rst_count", press_count, 0);
        check("rst_overflow", overflow_seen, 0);
        rst = 1'b0;
        fifo.delete();
        refresh();
        ev_q.delete();
        exp_q.delete();
`ifdef PS2_KBD_ASCII_EN
        asc_q.delete();
`endif
        pop_cnt = 0;
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (fifo.size() == 0 && state_dbg == IDLE && ps2_nextdata_n) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, done, 1);
    endtask

    // Scoreboard: drain the observed events against the expected queue.
    task automatic check_events(input string tag);
        int n;
        check({tag, "_ev_count"}, ev_q.size(), exp_q.size());
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
        ev_q.delete();
        exp_q.delete();
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        pop_cnt      = 0;
        rst          = 1'b1;
        ps2_overflow = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single make: exact latency and one pop pulse
        send(8'h1C);
        @(posedge clk); #1;
        check("t1_pop_low", ps2_nextdata_n, 0);
        check("t1_no_early_valid", key_valid, 0);
        @(posedge clk); #1;
        check("t1_pop_high", ps2_nextdata_n, 1);
        check("t1_valid", key_valid, 1);
        check("t1_event", {key_code, key_ext, key_release}, ev(8'h1C, 0, 0));
        check("t1_count", press_count, 1);
        check("t1_held", {key_held, held_code, held_ext}, {1'b1, 8'h1C, 1'b0});
        @(posedge clk); #1;
        check("t1_valid_drop", key_valid, 0);
        check("t1_pop_cnt", pop_cnt, 1);

        // Typematic repeats then release
        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        exp_q.push_back(ev(8'h1C, 0, 0));
        exp_q.push_back(ev(8'h1C, 0, 0));
        exp_q.push_back(ev(8'h1C, 0, 0));
        exp_q.push_back(ev(8'h1C, 0, 1));
        wait_idle("t2");
        check_events("t2");
        check("t2_count", press_count, 1);
        check("t2_held", {key_held, held_code}, {1'b0, 8'h1C});
        check("t2_pop_cnt", pop_cnt, 5);

        // Extended keys in both prefix orders, plus repeated prefixes
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        exp_q.push_back(ev(8'h75, 1, 0));
        exp_q.push_back(ev(8'h75, 1, 1));
        wait_idle("t3");
        check_events("t3");
        check("t3_count", press_count, 1);
        check("t3_held", {key_held, held_code, held_ext}, {1'b0, 8'h75, 1'b1});
        send(8'hE0); send(8'hE0); send(8'h6B);
        send(8'hF0); send(8'hE0); send(8'hF0); send(8'h6B);
        exp_q.push_back(ev(8'h6B, 1, 0));
        exp_q.push_back(ev(8'h6B, 1, 1));
        wait_idle("t3b");
        check_events("t3b");
        check("t3b_count", press_count, 2);
        check("t3b_held", key_held, 0);

        // New key replaces held key; releasing the old one leaves it held
        do_reset();
        send(8'h1C); send(8'h32); send(8'hF0); send(8'h1C);
        exp_q.push_back(ev(8'h1C, 0, 0));
        exp_q.push_back(ev(8'h32, 0, 0));
        exp_q.push_back(ev(8'h1C, 0, 1));
        wait_idle("t4");
        check_events("t4");
        check("t4_count", press_count, 2);
        check("t4_held", {key_held, held_code, held_ext}, {1'b1, 8'h32, 1'b0});

        // Same code with and without E0 is a distinct key
        send(8'hE0); send(8'h32);
        exp_q.push_back(ev(8'h32, 1, 0));
        wait_idle("t4b");
        check_events("t4b");
        check("t4b_count", press_count, 3);
        check("t4b_held", {key_held, held_code, held_ext}, {1'b1, 8'h32, 1'b1});

        // Reset discards a pending break prefix
        do_reset();
        send(8'h1C); send(8'hF0);
        wait_idle("t5a");
        check("t5a_count", press_count, 1);
        do_reset();
        send(8'h1C);
        exp_q.push_back(ev(8'h1C, 0, 0));
        wait_idle("t5");
        check_events("t5");
        check("t5_count", press_count, 1);
        check("t5_held", key_held, 1);

        // Sticky overflow
        ps2_overflow = 1'b1;
        @(posedge clk); #1;
        ps2_overflow = 1'b0;
        check("t6_ovf_set", overflow_seen, 1);
        repeat (5) @(posedge clk);
        #1;
        check("t6_ovf_sticky", overflow_seen, 1);
        do_reset();

`ifdef PS2_KBD_ASCII_EN
        send(8'h1C); send(8'h45); send(8'hE0); send(8'h75);
        wait_idle("t7");
        check("t7_asc_count", asc_q.size(), 3);
        if (asc_q.size() == 3) begin
            check("t7_asc_a", asc_q[0], 8'h61);
            check("t7_asc_0", asc_q[1], 8'h30);
            check("t7_asc_ext", asc_q[2], 8'h00);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
